uart_xmt_param: RTL and testbench
=================================

Name: uart_xmt_param

Overview:
- Parametrised UART transmitter combining control FSM, baud timing and shift datapath in one block; successor to the fixed 8-bit transmit datapath/controller pair.
- Adds configurable word size, an input holding FIFO, optional even/odd parity, 1 or 2 stop bits and an internal baud divider.
- Sits between the host data bus and the serial line; host pushes words, block frames and serialises them LSB first.

Parameters:
- WORD_SIZE, 8, data bits per frame (5..9)
- FIFO_DEPTH, 4, holding FIFO entries (power of 2, >=2)
- CLKS_PER_BIT, 16, Clock cycles per serial bit (>=2)

Ports:
- Clock  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- Data_Bus  in  WORD_SIZE  word to transmit
- Load_XMT_DR  in  1  write strobe; pushes Data_Bus into FIFO
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  1 = two stop bits, 0 = one
- Serial_out  out  1  serial line, idle high
- busy  out  1  frame in progress (any state but IDLE)
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- fifo_empty  out  1  FIFO holds 0 words
- overflow  out  1  sticky: write attempted while full and not popping
- tx_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (async, rst_b=0): Serial_out=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0, tx_done=0; FIFO pointers, bit counter and baud counter cleared; FSM to IDLE. Reset mid-frame aborts the frame immediately; queued words are discarded.
- FIFO: push when Load_XMT_DR=1 and (not full, or pop in same cycle). Push while full without pop: word dropped, overflow set until reset. Push and pop same cycle on empty: not allowed to bypass; word enters FIFO, popped earliest next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Serial_out=1. If FIFO non-empty: pop head into shift register, latch parity_mode and two_stop (held constant for the frame), go START. Config changes mid-frame have no effect until next frame.
- START: Serial_out=0 for CLKS_PER_BIT cycles, then DATA. Serial_out falls on the cycle after the pop cycle.
- DATA: Serial_out = shift[0]; every CLKS_PER_BIT cycles shift right, bit counter +1; after WORD_SIZE bits go PARITY if latched mode is 01/10, else STOP.
- PARITY: Serial_out = XOR of word (even) or its inverse (odd) for CLKS_PER_BIT cycles, then STOP.
- STOP: Serial_out=1 for CLKS_PER_BIT (one stop) or 2*CLKS_PER_BIT (two stop) cycles. On the last cycle tx_done=1; next state START directly (pop in same cycle) if FIFO non-empty, else IDLE. Back-to-back frames have no idle gap.
- Baud counter: width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, resets to 0 on every state change; no wrap drift.
- Frame length = CLKS_PER_BIT * (1 + WORD_SIZE + P + S), P in {0,1}, S in {1,2}.
- busy=1 from START entry through last STOP cycle inclusive.

Test Plan:
- WORD_SIZE=8, CLKS_PER_BIT=4, parity none, one stop, write 0xA5 -> Serial_out 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, 40-cycle frame, single tx_done on cycle 40, busy then 0, Serial_out stays 1.
- Same, parity_mode=01 then 10 with 0xA5 -> parity bit 0 (even) / 1 (odd); 44-cycle frame; parity_mode changed mid-frame does not alter the bit.
- two_stop=1, write 0x00 -> 0 start, eight 0 bits, 8 cycles high stop; frame 44 cycles.
- FIFO_DEPTH=4: write 6 words back-to-back while IDLE -> first popped, 4 queued, fifo_full=1, 6th dropped, overflow=1 sticky; 5 frames sent contiguously with no idle gap; fifo_empty=1 after 5th pop.
- Pull rst_b low mid-DATA of second frame -> Serial_out=1, busy=0, fifo_empty=1, overflow=0 asynchronously; after release, no residual transmission.
- Push on the same cycle as STOP-end pop with FIFO full -> push accepted, overflow stays 0, fifo_full remains 1.

Source files
------------

// File: rtl/uart_xmt_param.sv
// Parametrised UART transmitter: holding FIFO, baud timing, framing FSM and
// shift datapath. Words are sent LSB first with optional parity and 1 or 2
// stop bits; back-to-back frames follow each other with no idle gap.
module uart_xmt_param #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic [WORD_SIZE-1:0] Data_Bus,
  input  logic                 Load_XMT_DR,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 Serial_out,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow,
  output logic                 tx_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(WORD_SIZE);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_SIZE - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e r_state;
  state_e w_state_d;

  // Holding FIFO
  logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [WORD_SIZE-1:0] w_head;

  // Frame datapath; config is latched at pop and held for the whole frame
  logic [WORD_SIZE-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_par_en;
  logic                 r_two_stop;
  logic [BaudW-1:0]     r_baud;
  logic [BitW-1:0]      r_bit_cnt;
  logic                 w_baud_last;
  logic                 w_data_last;
  logic                 w_stop_end;

  assign w_full      = (r_count == CntFull);
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_last = (r_baud == BaudLast);
  assign w_data_last = (r_bit_cnt == BitLast);
  // In STOP the bit counter counts stop bits already completed
  assign w_stop_end  = (r_state == StStop) && w_baud_last && (!r_two_stop || r_bit_cnt[0]);
  assign w_pop       = !w_empty && ((r_state == StIdle) || w_stop_end);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
  assign w_push      = Load_XMT_DR && (!w_full || w_pop);

  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign overflow   = r_overflow;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Data_Bus;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (Load_XMT_DR && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_baud_last) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_baud_last && w_data_last) begin
          w_state_d = r_par_en ? StParity : StStop;
        end
      end
      StParity: begin
        if (w_baud_last) begin
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_stop_end) begin
          w_state_d = w_empty ? StIdle : StStart;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs: line level, busy and end-of-frame pulse
  always_comb begin
    Serial_out = 1'b1;
    busy       = 1'b1;
    tx_done    = 1'b0;
    unique case (r_state)
      StIdle:   busy       = 1'b0;
      StStart:  Serial_out = 1'b0;
      StData:   Serial_out = r_shift[0];
      StParity: Serial_out = r_par_bit;
      StStop:   tx_done    = w_stop_end;
      default:  busy       = 1'b0;
    endcase
  end

  // Baud and bit counters restart on every state change, so no drift accumulates
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
    end else if (w_state_d != r_state) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
    end else if (r_state != StIdle) begin
      if (w_baud_last) begin
        r_baud <= '0;
        if ((r_state == StData) || (r_state == StStop)) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  // Shift register load on pop, shift at each data bit boundary; frame config latch
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_par_bit  <= (^w_head) ^ (parity_mode == 2'b10);
      r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      r_two_stop <= two_stop;
    end else if ((r_state == StData) && w_baud_last) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_xmt_param.sv
// Bench for uart_xmt_param (WORD_SIZE=8, FIFO_DEPTH=4, CLKS_PER_BIT=4).
// Expected frames are queued when words are pushed and checked cycle by cycle
// as the DUT serialises them.
module tb_uart_xmt_param;

  localparam int CPB = 4;

  logic       Clock = 1'b0;
  logic       rst_b;
  logic [7:0] Data_Bus;
  logic       Load_XMT_DR;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       Serial_out;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       tx_done;

  uart_xmt_param #(
    .WORD_SIZE   (8),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clock      (Clock),
    .rst_b      (rst_b),
    .Data_Bus   (Data_Bus),
    .Load_XMT_DR(Load_XMT_DR),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .Serial_out (Serial_out),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .tx_done    (tx_done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       ts;
    int         len;  // expected frame length in clocks
    logic       par;  // expected parity bit (ignored when pm selects none)
  } vec_t;

  vec_t sb[$];
  vec_t vecs[8];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                           input int len, input logic par, input bit expect_frame);
    vec_t e;
    e = '{d, pm, ts, len, par};
    Data_Bus    = d;
    Load_XMT_DR = 1'b1;
    if (expect_frame) sb.push_back(e);
    @(negedge Clock);
    Load_XMT_DR = 1'b0;
  endtask

  // Checks one frame. contig: frame must start at the current cycle.
  // last: line must be idle afterwards. scramble: change config mid-frame.
  // inj: push inj_data on the last cycle of this frame.
  task automatic check_frame(input bit contig, input bit last, input bit scramble,
                             input bit inj, input logic [7:0] inj_data);
    vec_t e;
    vec_t ie;
    logic bits [16];
    int   waited;
    int   ser_mis;
    int   done_mis;
    int   busy_mis;
    int   nb;
    bit   par_on;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e      = sb.pop_front();
    nb     = e.len / CPB;
    par_on = (e.pm == 2'b01) || (e.pm == 2'b10);
    for (int k = 0; k < 16; k++) bits[k] = 1'b1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[1+k] = e.data[k];
    if (par_on) bits[9] = e.par;
    if (!contig) begin
      waited = 0;
      while (Serial_out !== 1'b0 && waited < 200) begin
        @(negedge Clock);
        waited++;
      end
      if (waited >= 200) begin
        chk("start_bit_timeout", 32'(waited), 32'd0);
        return;
      end
    end
    ser_mis  = 0;
    done_mis = 0;
    busy_mis = 0;
    for (int c = 0; c < e.len; c++) begin
      if (Serial_out !== bits[c / CPB]) ser_mis++;
      if (tx_done !== (c == e.len - 1)) done_mis++;
      if (busy !== 1'b1) busy_mis++;
      if (scramble && c == 6) begin
        parity_mode = ~e.pm;
        two_stop    = ~e.ts;
      end
      if (inj && c == e.len - 1) begin
        ie          = '{inj_data, 2'b00, 1'b0, 40, 1'b0};
        Data_Bus    = inj_data;
        Load_XMT_DR = 1'b1;
        sb.push_back(ie);
      end
      @(negedge Clock);
    end
    if (inj) Load_XMT_DR = 1'b0;
    chk($sformatf("serial_bad_cycles_%0h", e.data), 32'(ser_mis), 32'd0);
    chk($sformatf("txdone_bad_cycles_%0h", e.data), 32'(done_mis), 32'd0);
    chk($sformatf("busy_bad_cycles_%0h", e.data), 32'(busy_mis), 32'd0);
    if (nb < 10) chk("frame_len_table", 32'(nb), 32'd10);
    if (last) begin
      chk("idle_line_after_frame", 32'(Serial_out), 32'd1);
      chk("idle_busy_after_frame", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 40, 1'b0};
    vecs[1] = '{8'hA5, 2'b01, 1'b0, 44, 1'b0};
    vecs[2] = '{8'hA5, 2'b10, 1'b0, 44, 1'b1};
    vecs[3] = '{8'h00, 2'b00, 1'b1, 44, 1'b0};
    vecs[4] = '{8'h3C, 2'b10, 1'b1, 48, 1'b1};
    vecs[5] = '{8'hFF, 2'b01, 1'b0, 44, 1'b0};
    vecs[6] = '{8'h07, 2'b01, 1'b1, 48, 1'b1};
    vecs[7] = '{8'h07, 2'b11, 1'b0, 40, 1'b0};

    rst_b       = 1'b1;
    Load_XMT_DR = 1'b0;
    Data_Bus    = 8'h00;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    #2 rst_b = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_outputs", 32'({Serial_out, busy, fifo_full, fifo_empty, overflow, tx_done}),
        32'b100100);
    rst_b = 1'b1;
    repeat (2) @(negedge Clock);

    // Single frames over the vector table; config is scrambled mid-frame
    for (int i = 0; i < 8; i++) begin
      parity_mode = vecs[i].pm;
      two_stop    = vecs[i].ts;
      push_word(vecs[i].data, vecs[i].pm, vecs[i].ts, vecs[i].len, vecs[i].par, 1'b1);
      check_frame(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      repeat (3) @(negedge Clock);
    end

    // Burst of six words: one popped, four queued, sixth dropped
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_word(8'h11 * 8'(i + 1), 2'b00, 1'b0, 40, 1'b0, i < 5);
        end
        chk("burst_fifo_full", 32'(fifo_full), 32'd1);
        chk("burst_overflow_set", 32'(overflow), 32'd1);
      end
      begin
        check_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) check_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("burst_empty_after_5th_pop", 32'(fifo_empty), 32'd1);
        chk("burst_overflow_sticky", 32'(overflow), 32'd1);
        check_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      end
    join
    repeat (3) @(negedge Clock);

    // Reset in the middle of the second frame's data bits
    fork
      begin
        push_word(8'hC3, 2'b00, 1'b0, 40, 1'b0, 1'b1);
        push_word(8'h5A, 2'b00, 1'b0, 40, 1'b0, 1'b0);
        push_word(8'hF0, 2'b00, 1'b0, 40, 1'b0, 1'b0);
      end
      check_frame(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    join
    chk("second_frame_start", 32'(Serial_out), 32'd0);
    repeat (9) @(negedge Clock);
    #1 rst_b = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({Serial_out, busy, fifo_full, fifo_empty, overflow, tx_done}),
        32'b100100);
    @(negedge Clock);
    rst_b = 1'b1;
    viol  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clock);
      if (Serial_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) viol++;
    end
    chk("post_reset_quiet_cycles", 32'(viol), 32'd0);
    chk("post_reset_fifo_empty", 32'(fifo_empty), 32'd1);

    // Push into a full FIFO on the same cycle as the stop-end pop
    fork
      for (int i = 0; i < 5; i++) begin
        push_word(8'h21 + 8'(i), 2'b00, 1'b0, 40, 1'b0, 1'b1);
      end
      check_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
    join
    chk("pushpop_fifo_full", 32'(fifo_full), 32'd1);
    chk("pushpop_no_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) check_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("final_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
